// File: rtl/vram_feeder.sv
// vram_feeder: producer side of the vga block's pixel VRAM write port.
// Assembles RGB888 (R,G,B byte order) or little-endian RGB565 pixels from an
// 8-bit stream, expands 565 to 24 bits, and pushes exactly H*V pixels into
// the VRAM write port under vram_ready backpressure.
//
// Ports:
//   clk_sys, reset_n        clock, asynchronous active-low reset
//   start, abort            one-cycle control pulses (abort has priority)
//   fmt565, H, V            frame format and size, sampled at start
//   in_data/in_valid/in_ready  byte stream handshake
//   vram_ready/vram_req     VRAM write handshake (req is combinational)
//   r/g/b_vram_out          pixel currently held for VRAM
//   busy, frame_done        RUN indicator, end-of-frame pulse
//   pix_written, frame_cnt  progress and completed-frame counters
module vram_feeder #(
  parameter int PIX_W = 24
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic             fmt565,
  input  logic [15:0]      H,
  input  logic [15:0]      V,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             vram_ready,
  output logic             vram_req,
  output logic [7:0]       r_vram_out,
  output logic [7:0]       g_vram_out,
  output logic [7:0]       b_vram_out,
  output logic             busy,
  output logic             frame_done,
  output logic [PIX_W-1:0] pix_written,
  output logic [31:0]      frame_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  function automatic logic [7:0] expand5(input logic [4:0] v);
    return {v, v[4:2]};
  endfunction

  function automatic logic [7:0] expand6(input logic [5:0] v);
    return {v, v[5:4]};
  endfunction

  state_t           state;
  logic             fmt_q;
  logic [PIX_W-1:0] total_q;
  logic [PIX_W-1:0] asm_cnt;
  logic [1:0]       phase;
  logic [7:0]       byte0_p0, byte1_p0;
  logic [7:0]       r_p1, g_p1, b_p1;
  logic             vld_p1;
  logic [PIX_W-1:0] pix_written_q;
  logic [31:0]      frame_cnt_q;
  logic             frame_done_q;

  logic             accept, last_byte;
  logic [7:0]       nr, ng, nb;
  logic [PIX_W-1:0] hv_total, pix_next;

  assign hv_total  = PIX_W'(32'(H) * 32'(V));
  assign pix_next  = pix_written_q + PIX_W'(1);
  assign in_ready  = (state == S_RUN) && (asm_cnt < total_q) && (!vld_p1 || vram_ready);
  assign accept    = in_valid && in_ready;
  assign last_byte = fmt_q ? (phase == 2'd1) : (phase == 2'd2);
  // Combinational so the vga block sees req and ready in the same cycle.
  assign vram_req  = vld_p1 && vram_ready;

  assign r_vram_out  = r_p1;
  assign g_vram_out  = g_p1;
  assign b_vram_out  = b_p1;
  assign busy        = (state == S_RUN);
  assign frame_done  = frame_done_q;
  assign pix_written = pix_written_q;
  assign frame_cnt   = frame_cnt_q;

  // Pixel formed from the stored bytes plus the byte arriving now.
  always_comb begin
    nr = byte0_p0;
    ng = byte1_p0;
    nb = in_data;
    if (fmt_q) begin
      nr = expand5(in_data[7:3]);
      ng = expand6({in_data[2:0], byte0_p0[7:5]});
      nb = expand5(byte0_p0[4:0]);
    end
  end

  // stage p0 (byte collection) -> p1 (hold register facing VRAM)
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      fmt_q         <= 1'b0;
      total_q       <= '0;
      asm_cnt       <= '0;
      phase         <= 2'd0;
      byte0_p0      <= 8'd0;
      byte1_p0      <= 8'd0;
      r_p1          <= 8'd0;
      g_p1          <= 8'd0;
      b_p1          <= 8'd0;
      vld_p1        <= 1'b0;
      pix_written_q <= '0;
      frame_cnt_q   <= 32'd0;
      frame_done_q  <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (abort) begin
        state  <= S_IDLE;
        vld_p1 <= 1'b0;
        phase  <= 2'd0;
        // A write strobed in the abort cycle still reached the VRAM.
        if (vram_req) pix_written_q <= pix_next;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              fmt_q         <= fmt565;
              total_q       <= hv_total;
              pix_written_q <= '0;
              asm_cnt       <= '0;
              phase         <= 2'd0;
              vld_p1        <= 1'b0;
              if (hv_total == '0) begin
                state        <= S_DONE;
                frame_done_q <= 1'b1;
                frame_cnt_q  <= frame_cnt_q + 32'd1;
              end else begin
                state <= S_RUN;
              end
            end
          end
          S_RUN: begin
            if (vram_req) pix_written_q <= pix_next;
            if (accept && last_byte) begin
              // Reload wins over the drain in the same cycle: no bubble.
              r_p1    <= nr;
              g_p1    <= ng;
              b_p1    <= nb;
              vld_p1  <= 1'b1;
              asm_cnt <= asm_cnt + PIX_W'(1);
              phase   <= 2'd0;
            end else begin
              if (vram_req) vld_p1 <= 1'b0;
              if (accept) begin
                phase <= phase + 2'd1;
                if (phase == 2'd0) byte0_p0 <= in_data;
                else               byte1_p0 <= in_data;
              end
            end
            if (vram_req && (pix_next == total_q)) begin
              state        <= S_DONE;
              frame_done_q <= 1'b1;
              frame_cnt_q  <= frame_cnt_q + 32'd1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vram_feeder.sv
// Testbench for vram_feeder: table of single-pixel vectors, directed frame
// sequences (backpressure, abort, zero-size, restart, async reset) and
// randomized frames checked against a byte-stream reference model.
module tb_vram_feeder;
  localparam int PIX_W = 24;

  logic             clk_sys = 1'b0;
  logic             reset_n;
  logic             start, abort, fmt565;
  logic [15:0]      H, V;
  logic [7:0]       in_data;
  logic             in_valid, in_ready;
  logic             vram_ready, vram_req;
  logic [7:0]       r_vram_out, g_vram_out, b_vram_out;
  logic             busy, frame_done;
  logic [PIX_W-1:0] pix_written;
  logic [31:0]      frame_cnt;

  always #5 clk_sys = ~clk_sys;

  vram_feeder #(.PIX_W(PIX_W)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .start(start), .abort(abort),
    .fmt565(fmt565), .H(H), .V(V), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .vram_ready(vram_ready), .vram_req(vram_req),
    .r_vram_out(r_vram_out), .g_vram_out(g_vram_out), .b_vram_out(b_vram_out),
    .busy(busy), .frame_done(frame_done), .pix_written(pix_written),
    .frame_cnt(frame_cnt)
  );

  typedef logic [7:0]  bq_t[$];
  typedef logic [23:0] pq_t[$];
  typedef struct {
    bit          fmt;
    logic [7:0]  b0, b1, b2;
    logic [23:0] exp;
  } vec_t;

  int tot = 0;
  int bad = 0;
  int exp_frames = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  function automatic int frame_total(input int h, input int v);
    longint p;
    p = longint'(h) * longint'(v);
    return int'(p % (64'd1 << PIX_W));
  endfunction

  // Reference: pixels from a byte list using the format rules directly.
  function automatic pq_t model(input bit fmt, input bq_t b);
    pq_t q;
    int n, w, r5, g6, b5, r8, g8, b8;
    n = fmt ? b.size() / 2 : b.size() / 3;
    for (int k = 0; k < n; k++) begin
      if (fmt) begin
        w  = int'(b[2*k+1]) * 256 + int'(b[2*k]);
        r5 = (w >> 11) & 31;
        g6 = (w >> 5) & 63;
        b5 = w & 31;
        r8 = (r5 << 3) | (r5 >> 2);
        g8 = (g6 << 2) | (g6 >> 4);
        b8 = (b5 << 3) | (b5 >> 2);
        q.push_back({8'(r8), 8'(g8), 8'(b8)});
      end else begin
        q.push_back({b[3*k], b[3*k+1], b[3*k+2]});
      end
    end
    return q;
  endfunction

  task automatic run_frame(input string tag, input bit fmt, input int h, input int v,
                           input bq_t bytes, input pq_t exp_q, input int vld_pct,
                           input int rdy_pct, input int stall_at, input int stall_len,
                           input bit restart, output int done_cyc);
    int total, n, idx, wr, extra, extra_wr, dones, cyc, last_wr, after, budget;
    int stall_left, bpp;
    bit stall_begun;
    logic [23:0] stall_rgb;
    total = frame_total(h, v);
    n = bytes.size();
    bpp = fmt ? 2 : 3;
    idx = 0; wr = 0; extra = 0; extra_wr = 0; dones = 0; cyc = 0;
    last_wr = -1; after = 0; stall_left = 0; stall_begun = 0;
    stall_rgb = '0;
    budget = 40 * n + 200;
    done_cyc = -1;
    tick();
    fmt565 = fmt; H = 16'(h); V = 16'(v); start = 1'b1; in_valid = 1'b0; vram_ready = 1'b1;
    tick();
    start = 1'b0;
    while (cyc < budget && after < 3) begin
      start = restart && (cyc == 3);
      if (start) begin
        fmt565 = ~fmt; H = 16'd1; V = 16'd1;
      end
      in_valid = ($urandom_range(99) < vld_pct);
      in_data  = (idx < n) ? bytes[idx] : 8'hEE;
      if (stall_at >= 0 && !stall_begun && wr >= stall_at) begin
        stall_begun = 1'b1;
        stall_left  = stall_len;
      end
      vram_ready = (stall_left > 0) ? 1'b0 : ($urandom_range(99) < rdy_pct);
      @(negedge clk_sys);
      if (in_valid && in_ready) begin
        if (idx < n) idx++;
        else extra++;
      end
      if (vram_req) begin
        if (exp_q.size() > 0) chk({tag, " pixel"}, {r_vram_out, g_vram_out, b_vram_out}, exp_q.pop_front());
        else extra_wr++;
        wr++;
        last_wr = cyc;
      end
      if (stall_left > 0) begin
        chk({tag, " stall req"}, vram_req, 1'b0);
        if (stall_left == stall_len - 5) stall_rgb = {r_vram_out, g_vram_out, b_vram_out};
        if (stall_left == 1) begin
          chk({tag, " stall rgb stable"}, {r_vram_out, g_vram_out, b_vram_out}, stall_rgb);
          chk({tag, " stall bytes"}, idx, bpp * (wr + 1));
          chk({tag, " stall in_ready"}, in_ready, 1'b0);
        end
        stall_left--;
      end
      if (frame_done) begin
        dones++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (dones > 0) after++;
      cyc++;
      tick();
    end
    in_valid = 1'b0;
    vram_ready = 1'b0;
    start = 1'b0;
    exp_frames++;
    chk({tag, " done pulses"}, dones, 1);
    chk({tag, " writes"}, wr, total);
    chk({tag, " bytes used"}, idx, n);
    chk({tag, " over-consume"}, extra, 0);
    chk({tag, " extra writes"}, extra_wr, 0);
    chk({tag, " frame_cnt"}, frame_cnt, exp_frames);
    chk({tag, " pix_written"}, pix_written, total);
    chk({tag, " busy after"}, busy, 1'b0);
    if (total > 0) chk({tag, " done lag"}, done_cyc - last_wr, 1);
  endtask

  initial begin
    vec_t tbl[8];
    bq_t  bq;
    pq_t  pq;
    int   dc, idx, wr, cyc, h, v, fmt, n, fd_seen;

    tbl[0] = '{1'b1, 8'h1F, 8'hF8, 8'h00, 24'hFF00FF};
    tbl[1] = '{1'b1, 8'hE0, 8'h07, 8'h00, 24'h00FF00};
    tbl[2] = '{1'b1, 8'h00, 8'h00, 8'h00, 24'h000000};
    tbl[3] = '{1'b1, 8'hFF, 8'hFF, 8'h00, 24'hFFFFFF};
    tbl[4] = '{1'b1, 8'h21, 8'h10, 8'h00, 24'h100408};
    tbl[5] = '{1'b1, 8'h55, 8'hAA, 8'h00, 24'hAD49AD};
    tbl[6] = '{1'b0, 8'h12, 8'h34, 8'h56, 24'h123456};
    tbl[7] = '{1'b0, 8'hFF, 8'h00, 8'h80, 24'hFF0080};

    reset_n = 1'b1; start = 1'b0; abort = 1'b0; fmt565 = 1'b0; H = '0; V = '0;
    in_data = '0; in_valid = 1'b0; vram_ready = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("reset in_ready", in_ready, 1'b0);
    chk("reset vram_req", vram_req, 1'b0);
    chk("reset busy", busy, 1'b0);
    chk("reset frame_done", frame_done, 1'b0);
    chk("reset pix_written", pix_written, 0);
    chk("reset frame_cnt", frame_cnt, 0);
    chk("reset rgb", {r_vram_out, g_vram_out, b_vram_out}, 24'h0);
    repeat (2) @(posedge clk_sys);
    #1 reset_n = 1'b1;

    // single-pixel vector table
    for (int i = 0; i < 8; i++) begin
      bq = {};
      bq.push_back(tbl[i].b0);
      bq.push_back(tbl[i].b1);
      if (!tbl[i].fmt) bq.push_back(tbl[i].b2);
      pq = {};
      pq.push_back(tbl[i].exp);
      run_frame($sformatf("vec%0d", i), tbl[i].fmt, 1, 1, bq, pq, 100, 100, -1, 0, 1'b0, dc);
    end

    // 565 two-pixel frame
    bq = {8'h1F, 8'hF8, 8'hE0, 8'h07};
    pq = {24'hFF00FF, 24'h00FF00};
    run_frame("565 pair", 1'b1, 2, 1, bq, pq, 100, 100, -1, 0, 1'b0, dc);

    // 888 4x2 back-to-back, with a start pulse ignored mid-frame
    bq = {};
    for (int k = 0; k < 24; k++) bq.push_back(8'(k));
    run_frame("888 4x2", 1'b0, 4, 2, bq, model(1'b0, bq), 100, 100, -1, 0, 1'b1, dc);

    // backpressure: vram_ready low for 10 cycles mid-frame
    bq = {};
    for (int k = 0; k < 24; k++) bq.push_back(8'(8'hA0 + k));
    run_frame("stall", 1'b0, 8, 1, bq, model(1'b0, bq), 100, 100, 2, 10, 1'b0, dc);

    // zero-size frames: H=0 and a product truncated to zero
    bq = {};
    pq = {};
    run_frame("H0", 1'b0, 0, 5, bq, pq, 100, 100, -1, 0, 1'b0, dc);
    chk("H0 done cycle", dc, 0);
    run_frame("trunc0", 1'b1, 4096, 4096, bq, pq, 100, 100, -1, 0, 1'b0, dc);
    chk("trunc0 done cycle", dc, 0);

    // abort after 5 of 8 pixels, one byte into pixel 6
    tick();
    fmt565 = 1'b0; H = 16'd8; V = 16'd1; start = 1'b1;
    tick();
    start = 1'b0; in_valid = 1'b1; vram_ready = 1'b1;
    idx = 0; wr = 0; cyc = 0;
    while (!(wr == 5 && idx == 16) && cyc < 200) begin
      in_data = 8'(idx * 7 + 3);
      @(negedge clk_sys);
      if (in_valid && in_ready) idx++;
      if (vram_req) begin
        chk("abort pixel", {r_vram_out, g_vram_out, b_vram_out},
            {8'(wr * 21 + 3), 8'(wr * 21 + 10), 8'(wr * 21 + 17)});
        wr++;
      end
      cyc++;
      tick();
    end
    chk("abort setup reached", cyc < 200, 1'b1);
    in_valid = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    fd_seen = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_sys);
      if (frame_done) fd_seen++;
      if (k == 0) begin
        chk("abort busy", busy, 1'b0);
        chk("abort in_ready", in_ready, 1'b0);
        chk("abort vram_req", vram_req, 1'b0);
        chk("abort pix_written", pix_written, 5);
      end
      tick();
    end
    chk("abort no frame_done", fd_seen, 0);
    chk("abort frame_cnt", frame_cnt, exp_frames);

    // start and abort together: abort wins
    start = 1'b1; abort = 1'b1; H = 16'd2; V = 16'd2;
    tick();
    start = 1'b0; abort = 1'b0;
    @(negedge clk_sys);
    chk("start+abort idle", busy, 1'b0);
    tick();

    bq = {8'hA1, 8'hB2, 8'hC3};
    pq = {24'hA1B2C3};
    run_frame("after abort", 1'b0, 1, 1, bq, pq, 100, 100, -1, 0, 1'b0, dc);

    // randomized frames
    for (int f = 0; f < 6; f++) begin
      fmt = $urandom_range(1);
      h = $urandom_range(6, 1);
      v = $urandom_range(4, 1);
      n = h * v * (fmt ? 2 : 3);
      bq = {};
      for (int k = 0; k < n; k++) bq.push_back(8'($urandom));
      run_frame($sformatf("rand%0d", f), fmt[0], h, v, bq, model(fmt[0], bq),
                $urandom_range(100, 30), $urandom_range(100, 30), -1, 0, 1'b0, dc);
    end

    // H*V overflowing PIX_W: 16385*1024 = 2^24 + 1024
    bq = {};
    for (int k = 0; k < 2048; k++) bq.push_back(8'($urandom));
    run_frame("trunc", 1'b1, 16385, 1024, bq, model(1'b1, bq), 100, 100, -1, 0, 1'b0, dc);

    // asynchronous reset mid-frame
    tick();
    fmt565 = 1'b0; H = 16'd4; V = 16'd2; start = 1'b1;
    tick();
    start = 1'b0; in_valid = 1'b1; vram_ready = 1'b1; in_data = 8'h5A;
    repeat (6) tick();
    chk("pre-reset vram_req", vram_req, 1'b1);
    chk("pre-reset in_ready", in_ready, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("async in_ready", in_ready, 1'b0);
    chk("async vram_req", vram_req, 1'b0);
    chk("async busy", busy, 1'b0);
    chk("async rgb", {r_vram_out, g_vram_out, b_vram_out}, 24'h0);
    chk("async pix_written", pix_written, 0);
    chk("async frame_cnt", frame_cnt, 0);
    in_valid = 1'b0;
    tick();
    reset_n = 1'b1;
    exp_frames = 0;
    bq = {8'h0F, 8'h1E, 8'h2D};
    pq = {24'h0F1E2D};
    run_frame("post reset", 1'b0, 1, 1, bq, pq, 100, 100, -1, 0, 1'b0, dc);

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
